// File: rtl/bp_fpga_host_mmio_buffer.sv
// Buffers BP MMIO writes as (addr, data) word pairs; the host drains them over AXI-Lite reads (0x8 = count, 0xC = pop).
// Read data is registered on the AR handshake with one read outstanding; MMIO stalls unless two free words remain.
module bp_fpga_host_mmio_buffer #(
  parameter int S_AXIL_ADDR_WIDTH = 64,
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int els_p             = 64
) (
  input  logic                               clk_i,
  input  logic                               reset_i,

  input  logic                               mmio_v_i,
  input  logic [31:0]                        mmio_addr_i,
  input  logic [31:0]                        mmio_data_i,
  output logic                               mmio_ready_and_o,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]       s_axil_araddr,
  input  logic [2:0]                         s_axil_arprot,
  input  logic                               s_axil_arvalid,
  output logic                               s_axil_arready,

  output logic [S_AXIL_DATA_WIDTH-1:0]       s_axil_rdata,
  output logic [1:0]                         s_axil_rresp,
  output logic                               s_axil_rvalid,
  input  logic                               s_axil_rready,

  output logic [$clog2(els_p+1)-1:0]         count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  typedef enum logic {e_ready, e_resp} state_e;

  state_e                         state_r, state_n;
  logic [ptr_w-1:0]               rd_ptr_r, wr_ptr_r;
  logic [cnt_w-1:0]               count_r, count_n, inc, dec;
  logic [S_AXIL_DATA_WIDTH-1:0]   mem [els_p];
  logic [S_AXIL_DATA_WIDTH-1:0]   rdata_n;
  logic [1:0]                     rresp_n;
  logic [7:0]                     offset;
  logic                           push, pop, ar_hs, r_hs;

  // Upper address bits and protection are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{s_axil_araddr[S_AXIL_ADDR_WIDTH-1:8], s_axil_arprot};

  assign offset           = s_axil_araddr[7:0];
  assign mmio_ready_and_o = ~reset_i & (count_r <= cnt_w'(els_p-2));
  assign s_axil_arready   = ~reset_i & (state_r == e_ready);
  assign s_axil_rvalid    = (state_r == e_resp);
  assign count_o          = count_r;

  assign push  = mmio_v_i & mmio_ready_and_o;
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign r_hs  = s_axil_rvalid & s_axil_rready;
  assign pop   = ar_hs & (offset == 8'h0C) & (count_r != '0);

  assign inc     = push ? cnt_w'(2) : '0;
  assign dec     = pop  ? cnt_w'(1) : '0;
  assign count_n = count_r + inc - dec;

  always_comb begin
    state_n = state_r;
    rdata_n = '0;
    rresp_n = 2'b00;
    case (offset)
      8'h08:   rdata_n = S_AXIL_DATA_WIDTH'(count_r);
      8'h0C:   rdata_n = (count_r != '0) ? mem[rd_ptr_r] : '0;
      default: rresp_n = 2'b11;
    endcase
    case (state_r)
      e_ready: if (ar_hs) state_n = e_resp;
      e_resp:  if (r_hs)  state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_ready;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      if (push) wr_ptr_r <= wr_ptr_r + ptr_w'(2);
      if (pop)  rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      if (ar_hs) begin
        s_axil_rdata <= rdata_n;
        s_axil_rresp <= rresp_n;
      end
    end
  end

  // Data RAM is not reset; count/pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_r]              <= mmio_addr_i;
      mem[wr_ptr_r + ptr_w'(1)]  <= mmio_data_i;
    end
  end

endmodule

// File: doc/bp_fpga_host_mmio_buffer.md
BP_FPGA_HOST_MMIO_BUFFER -- requirements
Module: bp_fpga_host_mmio_buffer

Interface
REQ-001 Parameter S_AXIL_ADDR_WIDTH, default 64: AXI-Lite read address width.
REQ-002 Parameter S_AXIL_DATA_WIDTH, default 32: AXI-Lite read data width; SHALL be 32.
REQ-003 Parameter els_p, default 64: FIFO depth in 32-bit words; SHALL be an even power of two, at least 4.
REQ-004 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_i  in  1  reset, asynchronous and active-high.
REQ-006 mmio_v_i  in  1  MMIO request valid from the BP I/O side.
REQ-007 mmio_addr_i  in  32  MMIO request address.
REQ-008 mmio_data_i  in  32  MMIO request data.
REQ-009 mmio_ready_and_o  out  1  request accepted when both mmio_v_i and mmio_ready_and_o are high.
REQ-010 s_axil_araddr  in  S_AXIL_ADDR_WIDTH  read address.
REQ-011 s_axil_arvalid / s_axil_arready  in / out  1 / 1  AR handshake.
REQ-012 s_axil_arprot  in  3  ignored.
REQ-013 s_axil_rdata / s_axil_rresp  out / out  32 / 2  read data and response.
REQ-014 s_axil_rvalid / s_axil_rready  out / in  1 / 1  R handshake.
REQ-015 count_o  out  `BSG_WIDTH(els_p)  current FIFO occupancy in words, for debug.

Function
REQ-016 Storage: circular word FIFO, els_p entries, with rd_ptr/wr_ptr (log2(els_p) bits, wrapping at els_p) and count 0..els_p.
REQ-017 mmio_ready_and_o = (count <= els_p-2); on a push, addr SHALL be written at wr_ptr and data at wr_ptr+1 (mod els_p) in the same cycle, and wr_ptr += 2.
REQ-018 A push SHALL never split: either both words enqueue or neither does.
REQ-019 Read FSM states: e_ready (arready=1, rvalid=0) and e_resp (arready=0, rvalid=1).
REQ-020 e_ready -> e_resp on arvalid & arready; rdata/rresp SHALL be registered in that cycle.
REQ-021 e_resp -> e_ready on rvalid & rready; rdata/rresp SHALL hold stable while rvalid=1 and rready=0.
REQ-022 Decode uses araddr[7:0] only.
REQ-023 Offset 0x8: rdata = count zero-extended, sampled before any same-cycle push or pop; rresp = OKAY (2'b00); no pop.
REQ-024 Offset 0xC, count>0: rdata = fifo[rd_ptr]; rresp = OKAY; pop on the AR handshake, so rd_ptr += 1 and count -= 1.
REQ-025 Offset 0xC, count==0: rdata = 0; rresp = OKAY; no pop; pointers unchanged.
REQ-026 Any other offset: rdata = 0; rresp = DECERR (2'b11); no state change.
REQ-027 Simultaneous push and pop: count_next = count + 2 - 1; the popped word SHALL be the pre-push head.
REQ-028 A push accepted with count==0 SHALL be visible to an AR accepted on the following cycle or later.
REQ-029 At most one read SHALL be outstanding; arready SHALL be 0 in e_resp.
REQ-030 Full condition: a pop when count==els_p-1 SHALL raise mmio_ready_and_o combinationally in the next cycle.

Reset
REQ-031 On reset_i assertion, asynchronously: state = e_ready, rd_ptr = wr_ptr = count = 0, rvalid = 0, rdata = 0, rresp = 0.
REQ-032 While reset_i=1: arready=0 and mmio_ready_and_o=0.
REQ-033 After reset_i deasserts: arready=1 and mmio_ready_and_o=1.
REQ-034 Reset mid-response SHALL drop rvalid immediately and discard FIFO contents; FIFO data RAM need not be cleared.

Verification
REQ-035 Push (0x0010_1000, 0x41), then read 0x8 -> rdata=2; read 0xC twice -> 0x0010_1000 then 0x41; read 0x8 -> 0.
REQ-036 Read 0xC on empty -> rdata=0, OKAY, count_o stays 0; read 0x4 -> rdata=0, rresp=DECERR.
REQ-037 With els_p=64, 32 pushes -> count_o=64, mmio_ready_and_o=0; one 0xC read -> count_o=63, ready still 0; second read -> 62, ready=1.
REQ-038 With count=3, a push and a 0xC AR in the same cycle -> returns the old head, count_o=4, and wrap-around order is preserved across rd_ptr 63->0.
REQ-039 Hold rready=0 for 5 cycles after rvalid -> rdata stable, arready=0, no second pop.
REQ-040 Assert reset_i while rvalid=1 with count=6 -> rvalid=0 in the same cycle, count_o=0, and after deassertion a 0x8 read returns 0.
